// File: rtl/mux32to1_str_pkg.sv
`default_nettype none
// ============================================================================
// mux32to1_str_pkg : shared width constants for the 32:1 mux tree
// Revision 1.0
// ============================================================================
package mux32to1_str_pkg;

  localparam int N_IN  = 32;
  localparam int SEL_W = 5;

endpackage : mux32to1_str_pkg
`default_nettype wire

// File: rtl/mux32to1_str_mux2.sv
`default_nettype none
// ============================================================================
// mux2to1_str : gate-level 2:1 mux cell, out = s ? in1 : in0
// Revision 1.0
// ============================================================================
module mux2to1_str (
  input  logic in0,
  input  logic in1,
  input  logic s,
  output logic out
);

  logic w_s_n;

  // AND-OR form keeps an X/Z on the unselected input from reaching out.
  assign w_s_n = ~s;
  assign out   = (in0 & w_s_n) | (in1 & s);

endmodule : mux2to1_str
`default_nettype wire

// File: rtl/mux32to1_str.sv
`default_nettype none
// ============================================================================
// mux32to1_str : 32:1 bit mux as a 5-level tree of mux2 cells, plus a
//                registered copy of the result
// Revision 1.0
// ============================================================================
module mux32to1_str
  import mux32to1_str_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic [N_IN-1:0]  a,
  output logic             y,
  output logic             y_q
);

  // Heap-ordered tree: node n is fed by nodes 2n and 2n+1; leaves 32..63 hold a[0..31].
  logic [2*N_IN-1:1] w_tree;
  logic              y_d;

  assign w_tree[2*N_IN-1:N_IN] = a;

  for (genvar lvl = 0; lvl < SEL_W; lvl++) begin : g_lvl
    for (genvar k = 0; k < (N_IN >> (lvl + 1)); k++) begin : g_cell
      localparam int NODE = (N_IN >> (lvl + 1)) + k;
      mux2to1_str u_mux2 (
        .in0 (w_tree[2*NODE]),
        .in1 (w_tree[2*NODE+1]),
        .s   (sel[lvl]),
        .out (w_tree[NODE])
      );
    end
  end

  assign y_d = w_tree[1];
  assign y   = y_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

endmodule : mux32to1_str
`default_nettype wire

// File: tb/tb_mux32to1_str.sv
`default_nettype none
// ============================================================================
// tb_mux32to1_str : directed + random bench for mux32to1_str
// Revision 1.0
// ============================================================================
module tb_mux32to1_str;

  logic        clk;
  logic        rst;
  logic [4:0]  sel;
  logic [31:0] a;
  logic        y;
  logic        y_q;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  mux32to1_str dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .a   (a),
    .y   (y),
    .y_q (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive a pair on the falling edge, check y, then check y_q after the next rising edge.
  task automatic step(input string tag, input logic [4:0] s, input logic [31:0] d,
                      input logic exp_y);
    logic exp_reg;
    @(negedge clk);
    sel = s;
    a   = d;
    #2;
    check({tag, " y"}, y, exp_y);
    exp_q.push_back(exp_y);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s y_q: observed empty scoreboard expected entry", tag);
    end else begin
      exp_reg = exp_q.pop_front();
      check({tag, " y_q"}, y_q, exp_reg);
    end
  endtask

  initial begin
    logic [4:0]  rs;
    logic [31:0] ra;
    logic [31:0] one_hot;

    rst = 1'b1;
    sel = 5'd0;
    a   = 32'hFFFF_FFFF;
    #2;
    check("reset y", y, 1'b1);
    check("reset y_q", y_q, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset hold y_q", y_q, 1'b0);
    end

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release y_q", y_q, 1'b1);

    #2;
    rst = 1'b1;
    #1;
    check("async reset y_q", y_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step("onehot s0",  5'd0,  32'h0000_0001, 1'b1);
    step("onehot s1",  5'd1,  32'h0000_0002, 1'b1);
    step("onehot s2",  5'd2,  32'h0000_0004, 1'b1);
    step("onehot s3",  5'd3,  32'h0000_0008, 1'b1);
    step("onehot s31", 5'd31, 32'h8000_0000, 1'b1);
    step("onehot s30", 5'd30, 32'h4000_0000, 1'b1);
    step("onehot s29", 5'd29, 32'h2000_0000, 1'b1);
    step("onehot s28", 5'd28, 32'h1000_0000, 1'b1);

    for (int i = 0; i < 32; i++) begin
      one_hot = 32'd1 << i;
      step($sformatf("inv s%0d", i),  5'(i), ~one_hot, 1'b0);
      step($sformatf("hot s%0d", i),  5'(i),  one_hot, 1'b1);
    end

    step("mismatch s0",  5'd0,  32'h0000_0002, 1'b0);
    step("mismatch s31", 5'd31, 32'h7FFF_FFFF, 1'b0);

    // Unselected bits driven X must not disturb the selected path.
    step("x neighbour", 5'd7, {{24{1'bx}}, 8'h80}, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      rs = 5'($urandom_range(0, 31));
      ra = $urandom;
      step("random", rs, ra, ra[rs]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux32to1_str
`default_nettype wire
